// File: rtl/scan_ram.sv
// Dual-port scan RAM: independent write port plus a registered read port whose
// address comes from an auto-scanning pointer, a frozen pointer, or a manual address.
module scan_ram #(
  parameter int DATA_W   = 3,
  parameter int ADDR_W   = 5,
  parameter int TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        mode,
  input  logic              dir,
  input  logic [ADDR_W-1:0] man_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              wrap
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_MANUAL = 2'b10;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [DIV_W-1:0]  div;
  logic [ADDR_W-1:0] sel;
  logic              step;
  logic              at_edge;

  always_comb begin
    sel     = (mode == MODE_MANUAL) ? man_addr : ptr;
    step    = (mode == MODE_AUTO) && (div == DIV_LAST);
    at_edge = dir ? (ptr == '0) : (ptr == '1);
  end

  // NOTE: the array has no reset value; the reset branch only blocks writes
  // while reset_n is low, so contents survive a reset untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: every flop below uses <= so all state sees pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr  <= '0;
      div  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= step && at_edge;
      if (mode == MODE_MANUAL) begin
        ptr <= man_addr;
        div <= '0;
      end else if (mode == MODE_AUTO) begin
        if (step) begin
          div <= '0;
          ptr <= dir ? (ptr - ADDR_W'(1)) : (ptr + ADDR_W'(1));
        end else begin
          div <= div + DIV_W'(1);
        end
      end
    end
  end

  // Write-first read: a same-edge write to the selected word bypasses the array.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      rd_addr <= sel;
      rd_data <= (wr_en && (wr_addr == sel)) ? wr_data : mem[sel];
    end
  end

endmodule

// File: tb/tb_scan_ram.sv
// Directed bench for scan_ram (DATA_W=3, ADDR_W=5, TICK_DIV=4): fill, up/down scan,
// collision, hold, manual-to-auto and asynchronous reset, all with hand-derived expectations.
module tb_scan_ram;

  localparam int DATA_W   = 3;
  localparam int ADDR_W   = 5;
  localparam int TICK_DIV = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        mode;
  logic              dir;
  logic [ADDR_W-1:0] man_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wrap;

  int vectors    = 0;
  int miscompares = 0;

  scan_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .mode     (mode),
    .dir      (dir),
    .man_addr (man_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One rising edge, then return at the falling edge where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int fill_val(input int a);
    return (a * 3) % 8;
  endfunction

  task automatic check_out(input string tag, input int exp_addr, input int exp_wrap);
    check({tag, ".rd_addr"}, 32'(rd_addr), exp_addr);
    check({tag, ".rd_data"}, 32'(rd_data), fill_val(exp_addr));
    check({tag, ".wrap"}, 32'(wrap), exp_wrap);
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    mode     = 2'b01;
    dir      = 1'b0;
    man_addr = '0;
    step();
    step();
    check("reset.rd_addr", 32'(rd_addr), 0);
    check("reset.rd_data", 32'(rd_data), 0);
    check("reset.wrap", 32'(wrap), 0);

    // Fill in hold mode so the pointer stays at 0.
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(i);
      wr_data = DATA_W'(fill_val(i));
      step();
    end
    wr_en = 1'b0;

    // Up scan: ptr=0, div=0; after edge k rd_addr = ((k-1)/4) mod 32, wrap only after edge 128.
    mode = 2'b00;
    dir  = 1'b0;
    for (int k = 1; k <= 128; k++) begin
      step();
      check_out($sformatf("up[%0d]", k), ((k - 1) / 4) % 32, (k == 128) ? 1 : 0);
    end

    // Down scan from ptr=0, div=0.
    dir = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      step();
      check_out($sformatf("down[%0d]", j), (j <= 4) ? 0 : ((j <= 8) ? 31 : 30), (j == 4) ? 1 : 0);
    end

    // Two more edges: ptr=29, div=2.
    step();
    step();
    check_out("pre_hold", 29, 0);

    // Hold for 10 cycles, with a same-value write to show writes never move ptr.
    mode = 2'b01;
    for (int h = 0; h < 10; h++) begin
      wr_en   = (h == 3);
      wr_addr = ADDR_W'(28);
      wr_data = DATA_W'(fill_val(28));
      step();
      check_out($sformatf("hold[%0d]", h), 29, 0);
    end
    wr_en = 1'b0;
    mode  = 2'b00;
    step();
    check_out("resume[1]", 29, 0);
    step();
    check_out("resume[2]", 29, 0);
    step();
    check_out("resume[3]", 28, 0);

    // Collisions in manual mode on address 7 (mem[7] initially 5).
    mode     = 2'b10;
    man_addr = ADDR_W'(7);
    wr_en    = 1'b1;
    wr_addr  = ADDR_W'(7);
    wr_data  = DATA_W'(2);
    step();
    check("coll_a.rd_addr", 32'(rd_addr), 7);
    check("coll_a.rd_data", 32'(rd_data), 2);
    wr_data = DATA_W'(5);
    step();
    check("coll_b.rd_addr", 32'(rd_addr), 7);
    check("coll_b.rd_data", 32'(rd_data), 5);
    check("coll_b.wrap", 32'(wrap), 0);
    wr_en = 1'b0;
    step();
    check("after_coll.rd_data", 32'(rd_data), 5);

    // Manual to auto: 20 held for 4 edges, then 21.
    man_addr = ADDR_W'(20);
    step();
    check_out("man20", 20, 0);
    mode = 2'b00;
    dir  = 1'b0;
    for (int m = 1; m <= 5; m++) begin
      step();
      check_out($sformatf("man2auto[%0d]", m), (m <= 4) ? 20 : 21, 0);
    end

    // Park at ptr=9, scan one edge, then reset between edges.
    mode     = 2'b10;
    man_addr = ADDR_W'(9);
    step();
    mode = 2'b00;
    step();
    check_out("pre_reset", 9, 0);
    reset_n = 1'b0;
    #1;
    check("async.rd_addr", 32'(rd_addr), 0);
    check("async.rd_data", 32'(rd_data), 0);
    check("async.wrap", 32'(wrap), 0);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(3);
    wr_data = DATA_W'(6);
    step();
    check("in_reset.rd_addr", 32'(rd_addr), 0);
    wr_en   = 1'b0;
    reset_n = 1'b1;
    for (int r = 1; r <= 5; r++) begin
      step();
      check_out($sformatf("post_reset[%0d]", r), (r <= 4) ? 0 : 1, 0);
    end

    // Memory survives reset; the write issued during reset was dropped.
    mode     = 2'b10;
    man_addr = ADDR_W'(9);
    step();
    check_out("mem9_kept", 9, 0);
    man_addr = ADDR_W'(3);
    step();
    check_out("mem3_kept", 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/scan_ram.md
SCAN_RAM -- requirements
Module: scan_ram

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 3, meaning the word width in bits (DATA_W >= 1).
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the address width, with DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter TICK_DIV, default 1, meaning the number of clock cycles per auto-scan step (TICK_DIV >= 1).

Interface
REQ-004 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  the reset; it SHALL be asynchronous and active-low.
REQ-006 wr_en  in  1  write strobe, sampled each rising edge.
REQ-007 wr_addr  in  ADDR_W  write address.
REQ-008 wr_data  in  DATA_W  write data.
REQ-009 mode  in  2  read-address mode: 00 auto-scan, 01 hold, 10 manual, 11 reserved.
REQ-010 dir  in  1  scan direction: 0 increments, 1 decrements.
REQ-011 man_addr  in  ADDR_W  read address used in manual mode.
REQ-012 rd_addr  out  ADDR_W  registered address of the word currently on rd_data.
REQ-013 rd_data  out  DATA_W  registered read data.
REQ-014 wrap  out  1  one-cycle pulse on scan-pointer wrap-around.

Function
REQ-015 Storage SHALL be DEPTH x DATA_W, with a write port and a read port that operate independently in the same cycle.
REQ-016 When wr_en=1 at a rising edge, mem[wr_addr] SHALL take the value of wr_data.
REQ-017 The block SHALL keep an internal scan pointer ptr (ADDR_W bits) and a divider count div (0..TICK_DIV-1).
REQ-018 The read-select address sel SHALL be man_addr in mode 10, and ptr in every other mode.
REQ-019 On each rising edge, rd_addr SHALL take sel and rd_data SHALL take mem[sel], giving 1-cycle latency, and the two SHALL always be a consistent pair.
REQ-020 The read-write collision rule SHALL be write-first: if wr_en=1 and wr_addr==sel, rd_data SHALL take wr_data on that edge.
REQ-021 Auto mode (00), when div==TICK_DIV-1: div SHALL go to 0 and ptr SHALL go to ptr+1 (dir=0) or ptr-1 (dir=1), modulo DEPTH.
REQ-022 Auto mode (00), otherwise: div SHALL increment and ptr SHALL hold.
REQ-023 With TICK_DIV=1, ptr SHALL step every cycle.
REQ-024 In hold mode (01) and reserved mode (11), ptr and div SHALL be frozen, and auto-scan SHALL resume from the frozen div count.
REQ-025 In manual mode (10), ptr SHALL take man_addr and div SHALL take 0 every cycle, so a later return to auto mode steps from the last manual address after TICK_DIV cycles.
REQ-026 wrap SHALL be 1 for exactly the cycle following a step from DEPTH-1 to 0 (dir=0) or from 0 to DEPTH-1 (dir=1), and 0 otherwise; it SHALL never assert in modes 01, 10 or 11.
REQ-027 A change of dir SHALL take effect on the next step, with no extra stall.
REQ-028 Writes SHALL be accepted in every mode and SHALL never alter ptr or div.

Reset
REQ-029 While reset_n=0, the block SHALL immediately force ptr=0, div=0, rd_addr=0, rd_data=0 and wrap=0, independent of clk.
REQ-030 Memory contents SHALL NOT be cleared by reset, and a write presented while reset_n=0 SHALL be ignored.
REQ-031 After reset_n rises, the first auto step SHALL occur TICK_DIV rising edges later.

Verification (DATA_W=3, ADDR_W=5, TICK_DIV=4 unless stated)
REQ-032 Fill and scan: write mem[i]=(i*3)%8 for i=0..31, then mode=00, dir=0 -> rd_addr advances once every 4 cycles, rd_data==(rd_addr*3)%8 throughout, and wrap is high for exactly one cycle at the 31->0 step.
REQ-033 Down scan: from ptr=0, dir=1 -> rd_addr sequence 0,31,30, and wrap pulses once, on the 0->31 step.
REQ-034 Collision: mode=10, man_addr=7, wr_en=1, wr_addr=7, wr_data=5 -> rd_addr=7 and rd_data=5 on that same edge; mem[7] reads 5 thereafter.
REQ-035 Hold: mode=01 for 10 cycles mid-count (div=2) -> rd_addr is constant; after returning to 00 -> the next step occurs 2 cycles later.
REQ-036 Manual to auto: man_addr=20 in mode 10, then mode=00 -> rd_addr=20 for 4 cycles, then 21.
REQ-037 Async reset mid-scan: with ptr=9, pulse reset_n=0 between clock edges -> outputs read 0 before the next edge; after release, mode=10 with man_addr=9 returns the pre-reset mem[9] value.
